// File: rtl/ftsd_pkg.sv
// Shared constants for the 14-segment display message scroller.
package ftsd_pkg;

  localparam logic [5:0] BLANK    = 6'd63;
  localparam int         FTSD_NUM = 4;

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_SCROLL = 1'b1;

endpackage

// File: rtl/ftsd_scroll_buf_tick_gen.sv
// Modulo-DIV counter with synchronous clear; tick is high for the terminal-count cycle.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ftsd_scroll_buf.sv
// Message buffer that previews, then rotates, stored char codes across four
// display digits, plus the free-running scan select for the scan controller.
module ftsd_scroll_buf
  import ftsd_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int STEP_DIV  = 25000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [5:0]                   wr_data,
  output logic                         wr_ready,
  input  logic                         start,
  output logic                         scrolling,
  output logic [$clog2(MSG_DEPTH):0]   msg_len,
  output logic [5:0]                   digit0,
  output logic [5:0]                   digit1,
  output logic [5:0]                   digit2,
  output logic [5:0]                   digit3,
  output logic [1:0]                   ftsd_ctl_en
);

  localparam int OW = $clog2(MSG_DEPTH);
  localparam int LW = OW + 1;

  logic [0:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [OW-1:0] off_q, off_d;
  logic [1:0]    sel_q, sel_d;
  logic [5:0]    mem_q [MSG_DEPTH];
  logic [5:0]    dig_q [FTSD_NUM];
  logic [5:0]    dig_d [FTSD_NUM];

  logic scan_tick, step_tick, step_clr, wr_acc;

  // (off + k) mod len by one conditional subtract; off < len keeps the sum below 2*len.
  function automatic logic [LW-1:0] wrap_idx(input logic [OW-1:0] off, input int k,
                                             input logic [LW-1:0] len);
    logic [LW-1:0] s;
    s = LW'(off) + LW'(k);
    if (s >= len) s = s - len;
    return s;
  endfunction

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  // Step counter is held at zero outside SCROLL, so every entry starts a fresh step period.
  assign step_clr = clr || (state_q != ST_SCROLL);

  tick_gen #(.DIV(STEP_DIV)) u_step_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (step_clr),
    .tick  (step_tick)
  );

  assign wr_ready  = (state_q == ST_LOAD) && (len_q < LW'(MSG_DEPTH));
  assign wr_acc    = wr_en && wr_ready && !clr;
  assign scrolling = (state_q == ST_SCROLL);
  assign msg_len   = len_q;
  assign digit0    = dig_q[0];
  assign digit1    = dig_q[1];
  assign digit2    = dig_q[2];
  assign digit3    = dig_q[3];
  assign ftsd_ctl_en = sel_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    sel_d   = scan_tick ? sel_q + 2'd1 : sel_q;
    if (clr) begin
      state_d = ST_LOAD;
      len_d   = '0;
      off_d   = '0;
    end else if (state_q == ST_LOAD) begin
      if (wr_acc) len_d = len_q + 1'b1;
      if (start && ((len_q != '0) || wr_acc)) begin
        state_d = ST_SCROLL;
        off_d   = '0;
      end
    end else if (step_tick && (len_q >= LW'(FTSD_NUM))) begin
      off_d = ((LW'(off_q) + 1'b1) == len_q) ? '0 : off_q + 1'b1;
    end
  end

  // Digits follow the registered offset/length, so they lag those by one cycle.
  always_comb begin
    for (int k = 0; k < FTSD_NUM; k++) begin
      logic [LW-1:0] idx;
      idx = wrap_idx(off_q, k, len_q);
      if (clr || (LW'(k) >= len_q)) dig_d[k] = BLANK;
      else                          dig_d[k] = mem_q[idx[OW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      len_q   <= '0;
      off_q   <= '0;
      sel_q   <= '0;
      for (int k = 0; k < FTSD_NUM; k++) dig_q[k] <= BLANK;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      for (int k = 0; k < FTSD_NUM; k++) dig_q[k] <= dig_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[len_q[OW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_ftsd_scroll_buf.sv
// Directed bench for ftsd_scroll_buf with short scan/step dividers.
module tb_ftsd_scroll_buf;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, start;
  logic [5:0] wr_data;
  logic       wr_ready, scrolling;
  logic [4:0] msg_len;
  logic [5:0] digit0, digit1, digit2, digit3;
  logic [1:0] ftsd_ctl_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ftsd_scroll_buf #(.MSG_DEPTH(16), .SCAN_DIV(4), .STEP_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .start       (start),
    .scrolling   (scrolling),
    .msg_len     (msg_len),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .ftsd_ctl_en (ftsd_ctl_en)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; start = 1'b0; wr_data = '0;
    repeat (3) step();
    checks++;
    if (msg_len !== 5'd0) begin
      failures++; $display("FAIL reset_len got=%0d exp=0", msg_len);
    end
    checks++;
    if ({digit0, digit1, digit2, digit3} !== {4{6'd63}}) begin
      failures++; $display("FAIL reset_digits got=%h exp=%h", {digit0, digit1, digit2, digit3}, {4{6'd63}});
    end
    checks++;
    if (ftsd_ctl_en !== 2'd0 || scrolling !== 1'b0) begin
      failures++; $display("FAIL reset_ctl got sel=%0d scr=%0b exp sel=0 scr=0", ftsd_ctl_en, scrolling);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int n = 1; n <= 16; n++) begin
      logic [1:0] exp_sel;
      step();
      exp_sel = 2'((n / 4) % 4);
      checks++;
      if (ftsd_ctl_en !== exp_sel) begin
        failures++; $display("FAIL scan_sel cycle=%0d got=%0d exp=%0d", n, ftsd_ctl_en, exp_sel);
      end
    end
  endtask

  task automatic test_fill();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL fill_ready_empty got=%0b exp=1", wr_ready);
    end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 6'(i);
      step();
    end
    checks++;
    if (wr_ready !== 1'b0 || msg_len !== 5'd16) begin
      failures++; $display("FAIL fill_full got rdy=%0b len=%0d exp rdy=0 len=16", wr_ready, msg_len);
    end
    wr_data = 6'd20;
    step();
    wr_en = 1'b0;
    checks++;
    if (msg_len !== 5'd16) begin
      failures++; $display("FAIL fill_drop_len got=%0d exp=16", msg_len);
    end
    step();
    checks++;
    if ({digit0, digit1, digit2, digit3} !== {6'd0, 6'd1, 6'd2, 6'd3}) begin
      failures++; $display("FAIL fill_preview got=%h exp=%h", {digit0, digit1, digit2, digit3}, {6'd0, 6'd1, 6'd2, 6'd3});
    end
    do_clear();
  endtask

  task automatic test_scroll_wrap();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 6'(i);
      step();
    end
    wr_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (scrolling !== 1'b1) begin
      failures++; $display("FAIL wrap_enter got=%0b exp=1", scrolling);
    end
    repeat (2) step();
    for (int m = 0; m <= 6; m++) begin
      logic [23:0] exp_d;
      if (m > 0) repeat (4) step();
      exp_d = {6'(m % 6), 6'((m + 1) % 6), 6'((m + 2) % 6), 6'((m + 3) % 6)};
      checks++;
      if ({digit0, digit1, digit2, digit3} !== exp_d) begin
        failures++; $display("FAIL wrap_step m=%0d got=%h exp=%h", m, {digit0, digit1, digit2, digit3}, exp_d);
      end
    end
    do_clear();
  endtask

  task automatic test_short_msg();
    wr_en = 1'b1; wr_data = 6'd7; step();
    wr_data = 6'd8; step();
    wr_en = 1'b0; start = 1'b1; step();
    start = 1'b0;
    for (int s = 0; s < 10; s++) begin
      repeat (4) step();
      checks++;
      if ({digit0, digit1, digit2, digit3} !== {6'd7, 6'd8, 6'd63, 6'd63} || scrolling !== 1'b1) begin
        failures++; $display("FAIL short_hold step=%0d got=%h scr=%0b exp=%h scr=1", s,
                             {digit0, digit1, digit2, digit3}, scrolling, {6'd7, 6'd8, 6'd63, 6'd63});
      end
    end
    do_clear();
  endtask

  task automatic test_clr_scroll();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 6'(i);
      step();
    end
    wr_en = 1'b0; start = 1'b1; step();
    start = 1'b0;
    repeat (6) step();
    clr = 1'b1; wr_en = 1'b1; wr_data = 6'd9;
    step();
    clr = 1'b0; wr_en = 1'b0;
    checks++;
    if (scrolling !== 1'b0 || msg_len !== 5'd0) begin
      failures++; $display("FAIL clr_state got scr=%0b len=%0d exp scr=0 len=0", scrolling, msg_len);
    end
    checks++;
    if ({digit0, digit1, digit2, digit3} !== {4{6'd63}}) begin
      failures++; $display("FAIL clr_digits got=%h exp=%h", {digit0, digit1, digit2, digit3}, {4{6'd63}});
    end
    step();
    checks++;
    if (msg_len !== 5'd0 || {digit0, digit1, digit2, digit3} !== {4{6'd63}}) begin
      failures++; $display("FAIL clr_write_dropped got len=%0d dig=%h exp len=0 dig=%h", msg_len,
                           {digit0, digit1, digit2, digit3}, {4{6'd63}});
    end
  endtask

  task automatic test_start_empty();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (scrolling !== 1'b0) begin
      failures++; $display("FAIL start_empty got=%0b exp=0", scrolling);
    end
    start = 1'b1; wr_en = 1'b1; wr_data = 6'd9;
    step();
    start = 1'b0; wr_en = 1'b0;
    checks++;
    if (scrolling !== 1'b1 || msg_len !== 5'd1) begin
      failures++; $display("FAIL start_with_write got scr=%0b len=%0d exp scr=1 len=1", scrolling, msg_len);
    end
    repeat (6) step();
    checks++;
    if ({digit0, digit1, digit2, digit3} !== {6'd9, 6'd63, 6'd63, 6'd63}) begin
      failures++; $display("FAIL start_with_write_digits got=%h exp=%h", {digit0, digit1, digit2, digit3},
                           {6'd9, 6'd63, 6'd63, 6'd63});
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_fill();
    test_scroll_wrap();
    test_short_msg();
    test_clr_scroll();
    test_start_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
